// File: rtl/int_ctrl_if.sv
// Pipeline <-> interrupt controller signal bundle: irq lines, CP0 access port,
// request/ack handshake and PC-select outputs.
interface int_ctrl_if #(
  parameter int unsigned NUM_SRC = 6
);
  logic [NUM_SRC-1:0] irq_in;
  logic               cp0_we;
  logic [4:0]         cp0_addr;
  logic [31:0]        cp0_wdata;
  logic [31:0]        cp0_rdata;
  logic               int_req;
  logic [2:0]         int_id;
  logic               int_ack;
  logic [31:0]        ack_pc;
  logic               eret;
  logic [31:0]        int_vector;
  logic [31:0]        epc_out;

  modport master (
    output irq_in, cp0_we, cp0_addr, cp0_wdata, int_ack, ack_pc, eret,
    input  cp0_rdata, int_req, int_id, int_vector, epc_out
  );

  modport slave (
    input  irq_in, cp0_we, cp0_addr, cp0_wdata, int_ack, ack_pc, eret,
    output cp0_rdata, int_req, int_id, int_vector, epc_out
  );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects irq lines into Cause.IP, masks with SR,
// picks the lowest pending index and handshakes with exception entry.
module int_ctrl #(
  parameter int unsigned NUM_SRC = 6,
  parameter logic [31:0] VECTOR  = 32'h0000_4180
) (
  input logic       clk,
  input logic       rst,
  int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] ip_q, ip_d;
  logic [NUM_SRC-1:0] im_q, im_d;
  logic [NUM_SRC-1:0] irq_prev_q;
  logic               ie_q, ie_d;
  logic               exl_q, exl_d;
  logic [31:0]        epc_q, epc_d;
  logic [2:0]         id_q, id_d;

  logic               wr_sr, wr_cause, wr_epc;
  logic               pending;
  logic [NUM_SRC-1:0] active;
  logic [2:0]         win_id;
  logic [5:0]         im_ext, ip_ext;

  assign wr_sr    = bus.cp0_we && (bus.cp0_addr == 5'd12);
  assign wr_cause = bus.cp0_we && (bus.cp0_addr == 5'd13);
  assign wr_epc   = bus.cp0_we && (bus.cp0_addr == 5'd14);
  assign active   = ip_q & im_q;
  assign pending  = (|active) && ie_q && !exl_q;

  // Walk downwards so the lowest set index is the last one assigned.
  always_comb begin
    win_id = 3'd0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) win_id = 3'(i);
    end
  end

  // Software clear is applied before the new edges so a same-cycle edge wins.
  assign ip_d = (ip_q & (wr_cause ? bus.cp0_wdata[10 +: NUM_SRC] : {NUM_SRC{1'b1}}))
              | (bus.irq_in & ~irq_prev_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    im_d    = im_q;
    ie_d    = ie_q;
    exl_d   = exl_q;
    epc_d   = epc_q;
    if (wr_sr) begin
      im_d  = bus.cp0_wdata[10 +: NUM_SRC];
      ie_d  = bus.cp0_wdata[0];
      exl_d = bus.cp0_wdata[1];
    end
    if (wr_epc) epc_d = bus.cp0_wdata;
    if (bus.eret) exl_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pending) begin
          state_d = StReq;
          id_d    = win_id;
        end
      end
      StReq: begin
        if (bus.int_ack) begin
          epc_d   = bus.ack_pc;
          exl_d   = 1'b1;
          state_d = StService;
        end else if (!pending) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (bus.eret || (wr_sr && !bus.cp0_wdata[1])) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ip_q       <= '0;
      im_q       <= '0;
      irq_prev_q <= '0;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      epc_q      <= 32'h0;
      id_q       <= 3'd0;
    end else begin
      state_q    <= state_d;
      ip_q       <= ip_d;
      im_q       <= im_d;
      irq_prev_q <= bus.irq_in;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      epc_q      <= epc_d;
      id_q       <= id_d;
    end
  end

  assign im_ext = 6'(im_q);
  assign ip_ext = 6'(ip_q);

  always_comb begin
    bus.cp0_rdata = 32'h0;
    case (bus.cp0_addr)
      5'd12:   bus.cp0_rdata = {16'h0, im_ext, 8'h0, exl_q, ie_q};
      5'd13:   bus.cp0_rdata = {16'h0, ip_ext, 10'h0};
      5'd14:   bus.cp0_rdata = epc_q;
      5'd15:   bus.cp0_rdata = 32'h0000_0001;
      default: bus.cp0_rdata = 32'h0;
    endcase
  end

  assign bus.int_req    = (state_q == StReq);
  assign bus.int_id     = id_q;
  assign bus.int_vector = VECTOR;
  assign bus.epc_out    = epc_q;

endmodule
